// File: rtl/activation_ctrl.sv
// activation_ctrl: sequencer and configuration front-end for the activation unit.
//
// Latches one tile configuration (activation type, GELU constants, requant
// constants, tile length). It streams that many N_PE-wide beats into the unit's
// fixed 2-cycle pipeline. Results are collected in an output FIFO whose space is
// reserved before a beat is issued, so downstream backpressure never has to stall
// the pipeline.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   cfg_valid_i/cfg_ready_o   tile configuration handshake (accepted only when idle)
//   cfg_*_i                   activation type, GELU constants, requant constants, length
//   in_valid_i/in_ready_o     preactivation beat handshake, in_data_i
//   out_valid_o/out_ready_i   postactivation beat handshake, out_data_o, out_last_o
//   done_o                    one-cycle pulse once the whole tile has been delivered
//   busy_o                    a tile is running or draining
//   act_*_o                   drive the activation unit (data, enables, latched config)
//   act_data_i                activation unit result, valid two cycles after calc_en
module activation_ctrl #(
    parameter int unsigned N_PE       = 16,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ACT_W      = 2,
    parameter int unsigned GELU_W     = 8,
    parameter int unsigned RQC_W      = 8,
    parameter int unsigned RQA_W      = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       cfg_valid_i,
    output logic                       cfg_ready_o,
    input  logic [ACT_W-1:0]           cfg_activation_i,
    input  logic signed [GELU_W-1:0]   cfg_one_i,
    input  logic signed [GELU_W-1:0]   cfg_b_i,
    input  logic signed [GELU_W-1:0]   cfg_c_i,
    input  logic [RQC_W-1:0]           cfg_rq_mult_i,
    input  logic [RQC_W-1:0]           cfg_rq_shift_i,
    input  logic signed [RQA_W-1:0]    cfg_rq_add_i,
    input  logic [LEN_W-1:0]           cfg_len_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [N_PE*DATA_W-1:0]     in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [N_PE*DATA_W-1:0]     out_data_o,
    output logic                       out_last_o,
    output logic                       done_o,
    output logic                       busy_o,
    output logic [N_PE*DATA_W-1:0]     act_data_o,
    output logic                       act_calc_en_o,
    output logic                       act_calc_en_q_o,
    output logic [ACT_W-1:0]           act_activation_o,
    output logic signed [GELU_W-1:0]   act_one_o,
    output logic signed [GELU_W-1:0]   act_b_o,
    output logic signed [GELU_W-1:0]   act_c_o,
    output logic [RQC_W-1:0]           act_rq_mult_o,
    output logic [RQC_W-1:0]           act_rq_shift_o,
    output logic signed [RQA_W-1:0]    act_rq_add_o,
    input  logic [N_PE*DATA_W-1:0]     act_data_i
);

    localparam int unsigned BEAT_W = N_PE * DATA_W;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W  = CNT_W + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                    state_q;
    logic [LEN_W-1:0]          remaining_q;
    logic [1:0]                vld_q;       // [0] = stage 0, [1] = stage 1
    logic [1:0]                tag_q;       // last-beat tag travelling with vld_q
    logic                      done_q;
    logic [ACT_W-1:0]          act_q;
    logic signed [GELU_W-1:0]  one_q, b_q, c_q;
    logic [RQC_W-1:0]          mult_q, shift_q;
    logic signed [RQA_W-1:0]   add_q;

    logic [BEAT_W-1:0]         mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]     mem_last_q;
    logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]          count_q, count_d;

    logic [1:0]                inflight_s;
    logic [OCC_W-1:0]          occ_s;
    logic                      in_ready_s, in_fire_s, push_s, pop_s;

    // Credit check: FIFO entries plus beats still in the pipeline must leave room.
    // A pop in the same cycle is deliberately not credited back.
    always_comb begin
        inflight_s = {1'b0, vld_q[0]} + {1'b0, vld_q[1]};
        occ_s      = OCC_W'(count_q) + OCC_W'(inflight_s);
        in_ready_s = (state_q == RUN) && (remaining_q != {LEN_W{1'b0}})
                     && (occ_s < OCC_W'(FIFO_DEPTH));
        in_fire_s  = in_valid_i && in_ready_s;
        push_s     = vld_q[1];
        pop_s      = out_ready_i && (count_q != CNT_W'(0));
    end

    // FIFO occupancy for the next cycle; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (push_s && !pop_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_s && pop_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Tile sequencer: config latch, beat counting, pipeline valid/tag shift, done pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            remaining_q <= {LEN_W{1'b0}};
            vld_q       <= 2'b00;
            tag_q       <= 2'b00;
            done_q      <= 1'b0;
            act_q       <= {ACT_W{1'b0}};
            one_q       <= {GELU_W{1'b0}};
            b_q         <= {GELU_W{1'b0}};
            c_q         <= {GELU_W{1'b0}};
            mult_q      <= {RQC_W{1'b0}};
            shift_q     <= {RQC_W{1'b0}};
            add_q       <= {RQA_W{1'b0}};
        end else begin
            done_q <= 1'b0;
            vld_q  <= {vld_q[0], in_fire_s};
            tag_q  <= {tag_q[0], in_fire_s && (remaining_q == LEN_W'(1))};
            case (state_q)
                IDLE: begin
                    if (cfg_valid_i) begin
                        act_q       <= cfg_activation_i;
                        one_q       <= cfg_one_i;
                        b_q         <= cfg_b_i;
                        c_q         <= cfg_c_i;
                        mult_q      <= cfg_rq_mult_i;
                        shift_q     <= cfg_rq_shift_i;
                        add_q       <= cfg_rq_add_i;
                        remaining_q <= cfg_len_i;
                        if (cfg_len_i == LEN_W'(0)) begin
                            done_q <= 1'b1;     // empty tile completes immediately
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (in_fire_s) begin
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // All beats are issued: the tile is delivered once nothing is left
                    // in the pipeline and the FIFO empties with this cycle's pop.
                    if ((count_d == CNT_W'(0)) && (vld_q == 2'b00)) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output FIFO storage: write activation results from stage 1, advance on pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {BEAT_W{1'b0}};
            end
            mem_last_q <= {FIFO_DEPTH{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q]      <= act_data_i;
                mem_last_q[wr_ptr_q] <= tag_q[1];
                wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? PTR_W'(0) : wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? PTR_W'(0) : rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    assign cfg_ready_o      = (state_q == IDLE);
    assign busy_o           = (state_q != IDLE);
    assign in_ready_o       = in_ready_s;
    assign act_calc_en_o    = in_fire_s;
    assign act_calc_en_q_o  = vld_q[0];
    assign act_data_o       = in_data_i;
    assign out_valid_o      = (count_q != CNT_W'(0));
    assign out_data_o       = mem_q[rd_ptr_q];
    assign out_last_o       = out_valid_o && mem_last_q[rd_ptr_q];
    assign done_o           = done_q;
    assign act_activation_o = act_q;
    assign act_one_o        = one_q;
    assign act_b_o          = b_q;
    assign act_c_o          = c_q;
    assign act_rq_mult_o    = mult_q;
    assign act_rq_shift_o   = shift_q;
    assign act_rq_add_o     = add_q;

endmodule

// File: tb/tb_activation_ctrl.sv
// Self-checking bench for activation_ctrl. A stand-in activation unit (2-cycle
// pipeline) drives act_data_i; a transaction-level model predicts every output.
module tb_activation_ctrl;
    localparam int N_PE  = 16;
    localparam int BW    = 128;
    localparam int DEPTH = 4;
    typedef logic [BW-1:0] w_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    logic              cfg_valid_i = 1'b0, cfg_ready_o;
    logic [1:0]        cfg_activation_i = 2'd0;
    logic signed [7:0] cfg_one_i = 8'sd0, cfg_b_i = 8'sd0, cfg_c_i = 8'sd0, cfg_rq_add_i = 8'sd0;
    logic [7:0]        cfg_rq_mult_i = 8'd0, cfg_rq_shift_i = 8'd0;
    logic [15:0]       cfg_len_i = 16'd0;
    logic              in_valid_i = 1'b0, in_ready_o;
    logic [BW-1:0]     in_data_i = '0;
    logic              out_valid_o, out_ready_i = 1'b0, out_last_o, done_o, busy_o;
    logic [BW-1:0]     out_data_o, act_data_o, act_data_i;
    logic              act_calc_en_o, act_calc_en_q_o;
    logic [1:0]        act_activation_o;
    logic signed [7:0] act_one_o, act_b_o, act_c_o, act_rq_add_o;
    logic [7:0]        act_rq_mult_o, act_rq_shift_o;

    activation_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .cfg_activation_i(cfg_activation_i), .cfg_one_i(cfg_one_i), .cfg_b_i(cfg_b_i),
        .cfg_c_i(cfg_c_i), .cfg_rq_mult_i(cfg_rq_mult_i), .cfg_rq_shift_i(cfg_rq_shift_i),
        .cfg_rq_add_i(cfg_rq_add_i), .cfg_len_i(cfg_len_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_last_o(out_last_o), .done_o(done_o), .busy_o(busy_o),
        .act_data_o(act_data_o), .act_calc_en_o(act_calc_en_o), .act_calc_en_q_o(act_calc_en_q_o),
        .act_activation_o(act_activation_o), .act_one_o(act_one_o), .act_b_o(act_b_o),
        .act_c_o(act_c_o), .act_rq_mult_o(act_rq_mult_o), .act_rq_shift_o(act_rq_shift_o),
        .act_rq_add_o(act_rq_add_o), .act_data_i(act_data_i)
    );

    // Reference activation: 0 identity, 1 relu, 2 toy GELU using every constant; saturated.
    function automatic w_t act_fn(input w_t x, input logic [1:0] a, input logic signed [7:0] one,
                                  input logic signed [7:0] b, input logic signed [7:0] c,
                                  input logic [7:0] mult, input logic [7:0] shift,
                                  input logic signed [7:0] add);
        w_t r;
        int v, y;
        r = '0;
        for (int l = 0; l < N_PE; l++) begin
            v = int'($signed(x[l*8 +: 8]));
            case (a)
                2'd1:    y = (v < 0) ? 0 : v;
                2'd2:    y = (((v * int'(one) + int'(b)) * int'(mult)) >>> int'(shift[2:0]))
                             + int'(add) + int'(c);
                default: y = v;
            endcase
            if (y > 127) y = 127;
            if (y < -128) y = -128;
            r[l*8 +: 8] = y[7:0];
        end
        return r;
    endfunction

    // Stand-in activation unit: stage 1 on calc_en, stage 2 on calc_en_q.
    w_t stub_s1 = '0, stub_s2 = '0;
    always @(posedge clk_i) begin
        if (act_calc_en_o) stub_s1 <= act_fn(act_data_o, act_activation_o, act_one_o, act_b_o,
                                             act_c_o, act_rq_mult_o, act_rq_shift_o, act_rq_add_o);
        if (act_calc_en_q_o) stub_s2 <= stub_s1;
    end
    assign act_data_i = stub_s2;

    int n_checks = 0, n_fail = 0, cyc = 0;
    task automatic chk(input string name, input w_t act, input w_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Downstream readiness: 0 always ready, 1 random, 2 stalled.
    int ready_mode = 0;
    always @(posedge clk_i) begin
        #1;
        case (ready_mode)
            0:       out_ready_i = 1'b1;
            1:       out_ready_i = 1'($urandom_range(1));
            default: out_ready_i = 1'b0;
        endcase
    end

    // Transaction-level model state.
    typedef struct { w_t data; bit last; int avail; } exp_t;
    exp_t sb[$];
    bit tile_open = 0, done_next = 0, ceq_prev = 0, win_on = 0;
    int remaining = 0, outstanding = 0, win_fires = 0;
    logic [1:0] m_act = 2'd0;
    logic signed [7:0] m_one = 8'sd0, m_b = 8'sd0, m_c = 8'sd0, m_add = 8'sd0;
    logic [7:0] m_mult = 8'd0, m_shift = 8'd0;
    int first_fire = -1, last_fire = -1, first_ov = -1, last_pop = -1, done_cyc = -1, cfg_cyc = -1;
    w_t first_out = '0;

    // Compare process: check DUT against the model, then advance the model one cycle.
    always @(negedge clk_i) begin
        bit e_ready, e_ov, fire, pop, cfgf, lst;
        exp_t e;
        if (rst_i) begin
            chk("rst_cfg_ready", w_t'(cfg_ready_o), w_t'(1));
            chk("rst_in_ready", w_t'(in_ready_o), w_t'(0));
            chk("rst_out_valid", w_t'(out_valid_o), w_t'(0));
            chk("rst_out_last", w_t'(out_last_o), w_t'(0));
            chk("rst_done", w_t'(done_o), w_t'(0));
            chk("rst_busy", w_t'(busy_o), w_t'(0));
            chk("rst_calc_en", w_t'(act_calc_en_o), w_t'(0));
            chk("rst_calc_en_q", w_t'(act_calc_en_q_o), w_t'(0));
            chk("rst_act", w_t'(act_activation_o), w_t'(0));
            chk("rst_consts", w_t'({act_one_o, act_b_o, act_c_o, act_rq_mult_o, act_rq_shift_o, act_rq_add_o}), w_t'(0));
            chk("rst_out_data", out_data_o, w_t'(0));
            sb.delete();
            tile_open = 0; done_next = 0; ceq_prev = 0; remaining = 0; outstanding = 0;
            m_act = 2'd0; m_one = 8'sd0; m_b = 8'sd0; m_c = 8'sd0; m_add = 8'sd0; m_mult = 8'd0; m_shift = 8'd0;
        end else begin
            e_ready = tile_open && (remaining > 0) && (outstanding < DEPTH);
            e_ov    = (sb.size() > 0) && (sb[0].avail <= cyc);
            chk("in_ready", w_t'(in_ready_o), w_t'(e_ready));
            chk("cfg_ready", w_t'(cfg_ready_o), w_t'(!tile_open));
            chk("busy", w_t'(busy_o), w_t'(tile_open));
            chk("out_valid", w_t'(out_valid_o), w_t'(e_ov));
            chk("done", w_t'(done_o), w_t'(done_next));
            chk("calc_en", w_t'(act_calc_en_o), w_t'(in_valid_i && e_ready));
            chk("calc_en_q", w_t'(act_calc_en_q_o), w_t'(ceq_prev));
            chk("act_data_o", act_data_o, in_data_i);
            chk("act_cfg", w_t'({act_activation_o, act_one_o, act_b_o, act_c_o, act_rq_mult_o, act_rq_shift_o, act_rq_add_o}),
                w_t'({m_act, m_one, m_b, m_c, m_mult, m_shift, m_add}));
            if (e_ov) begin
                chk("out_data", out_data_o, sb[0].data);
                chk("out_last", w_t'(out_last_o), w_t'(sb[0].last));
            end
            fire = in_valid_i && e_ready;
            pop  = e_ov && out_ready_i;
            cfgf = cfg_valid_i && !tile_open;
            if (fire && first_fire < 0) first_fire = cyc;
            if (fire) last_fire = cyc;
            if (fire && win_on) win_fires++;
            if (out_valid_o && first_ov < 0) begin first_ov = cyc; first_out = out_data_o; end
            if (done_o && done_cyc < 0) done_cyc = cyc;
            if (cfgf) cfg_cyc = cyc;
            ceq_prev  = fire;
            done_next = 0;
            if (fire) begin
                e.data  = act_fn(in_data_i, m_act, m_one, m_b, m_c, m_mult, m_shift, m_add);
                e.last  = (remaining == 1);
                e.avail = cyc + 3;
                sb.push_back(e);
                remaining--;
                outstanding++;
            end
            if (pop) begin
                lst = sb[0].last;
                void'(sb.pop_front());
                outstanding--;
                if (lst) begin tile_open = 0; done_next = 1; last_pop = cyc; end
            end
            if (cfgf) begin
                m_act = cfg_activation_i; m_one = cfg_one_i; m_b = cfg_b_i; m_c = cfg_c_i;
                m_mult = cfg_rq_mult_i; m_shift = cfg_rq_shift_i; m_add = cfg_rq_add_i;
                remaining = int'(cfg_len_i);
                if (cfg_len_i == 16'd0) done_next = 1;
                else tile_open = 1;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic arm();
        first_fire = -1; last_fire = -1; first_ov = -1; last_pop = -1; done_cyc = -1; cfg_cyc = -1;
    endtask

    task automatic do_cfg(input logic [1:0] a, input logic [7:0] one, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] mult, input logic [7:0] shift,
                          input logic [7:0] add, input logic [15:0] len);
        int n = 0;
        cfg_activation_i = a; cfg_one_i = one; cfg_b_i = b; cfg_c_i = c;
        cfg_rq_mult_i = mult; cfg_rq_shift_i = shift; cfg_rq_add_i = add; cfg_len_i = len;
        cfg_valid_i = 1'b1;
        while (1) begin
            @(negedge clk_i);
            if (cfg_ready_o) break;
            n++;
            if (n > 500) begin chk("cfg_timeout", w_t'(1), w_t'(0)); break; end
        end
        tick();
        cfg_valid_i = 1'b0;
    endtask

    function automatic w_t gen(input int pat, input int b);
        w_t r;
        int v;
        r = '0;
        for (int l = 0; l < N_PE; l++) begin
            case (pat)
                0: v = l * 3 - 20 + b;
                1: begin
                    case ((l + b) % 4)
                        0:       v = -128;
                        1:       v = -1;
                        2:       v = 0;
                        default: v = 127;
                    endcase
                end
                default: v = int'($urandom_range(255)) - 128;
            endcase
            r[l*8 +: 8] = v[7:0];
        end
        return r;
    endfunction

    task automatic send_tile(input int len, input int pat, input int unsigned vprob);
        for (int b = 0; b < len; b++) begin
            int n = 0;
            bit acc = 0;
            in_data_i = gen(pat, b);
            while (!acc) begin
                in_valid_i = ($urandom_range(99) < vprob);
                @(negedge clk_i);
                acc = in_valid_i && in_ready_o;
                tick();
                n++;
                if (n > 2000) begin chk("send_timeout", w_t'(1), w_t'(0)); in_valid_i = 1'b0; return; end
            end
        end
        in_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (1) begin
            @(negedge clk_i);
            if (!busy_o) break;
            n++;
            if (n > 3000) begin chk("idle_timeout", w_t'(1), w_t'(0)); break; end
        end
        tick();
        tick();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        rst_i = 1'b0;
        tick();

        // IDENTITY, len 8, full throughput.
        ready_mode = 0;
        arm();
        do_cfg(2'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 16'd8);
        send_tile(8, 0, 100);
        wait_idle();
        chk("t1_first_out_latency", w_t'(first_ov - first_fire), w_t'(3));
        chk("t1_back_to_back", w_t'(last_fire - first_fire), w_t'(7));
        chk("t1_done_after_pop", w_t'(done_cyc - last_pop), w_t'(1));
        chk("t1_lane0", w_t'(first_out[7:0]), w_t'(8'hEC));

        // RELU on {-128,-1,0,127}.
        arm();
        do_cfg(2'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 16'd4);
        send_tile(4, 1, 100);
        wait_idle();
        chk("t2_relu_lane0", w_t'(first_out[7:0]), w_t'(8'h00));
        chk("t2_relu_lane1", w_t'(first_out[15:8]), w_t'(8'h00));
        chk("t2_relu_lane3", w_t'(first_out[31:24]), w_t'(8'h7F));

        // GELU, len 64, downstream stalled for 20 cycles.
        arm();
        ready_mode = 2;
        do_cfg(2'd2, 8'd2, 8'hFD, 8'd5, 8'd45, 8'd3, 8'hFE, 16'd64);
        win_fires = 0;
        win_on = 1;
        fork
            send_tile(64, 0, 100);
            begin
                repeat (20) tick();
                win_on = 0;
                chk("t3_accepts_while_stalled", w_t'(win_fires), w_t'(4));
                ready_mode = 0;
            end
        join
        wait_idle();
        chk("t3_gelu_lane10", w_t'(first_out[87:80]), w_t'(8'd98));

        // Config offered mid-tile must be ignored.
        do_cfg(2'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 16'd6);
        fork
            send_tile(6, 2, 50);
            begin
                repeat (3) tick();
                cfg_activation_i = 2'd2;
                cfg_one_i = 8'sd7;
                cfg_valid_i = 1'b1;
                repeat (2) tick();
                cfg_valid_i = 1'b0;
            end
        join
        wait_idle();
        chk("t4_act_unchanged", w_t'(act_activation_o), w_t'(2'd1));

        // Zero-length tile.
        arm();
        in_valid_i = 1'b1;
        do_cfg(2'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 16'd0);
        tick();
        tick();
        in_valid_i = 1'b0;
        chk("t5_done_next_cycle", w_t'(done_cyc - cfg_cyc), w_t'(1));
        chk("t5_idle", w_t'(busy_o), w_t'(0));

        // Reset while draining with two beats in flight.
        do_cfg(2'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 16'd3);
        send_tile(3, 2, 100);
        chk("t6_stage0_busy", w_t'(act_calc_en_q_o), w_t'(1));
        chk("t6_out_valid_before", w_t'(out_valid_o), w_t'(1));
        #1 rst_i = 1'b1;
        #1;
        chk("t6_out_valid_async", w_t'(out_valid_o), w_t'(0));
        chk("t6_busy_async", w_t'(busy_o), w_t'(0));
        chk("t6_cfg_ready_async", w_t'(cfg_ready_o), w_t'(1));
        tick();
        rst_i = 1'b0;
        tick();
        do_cfg(2'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 16'd2);
        send_tile(2, 2, 100);
        wait_idle();

        // Randomized tiles.
        for (int t = 0; t < 14; t++) begin
            ready_mode = int'($urandom_range(1));
            do_cfg(2'($urandom_range(2)), 8'($urandom_range(255)), 8'($urandom_range(255)),
                   8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(7)),
                   8'($urandom_range(255)), 16'((t % 7 == 6) ? 0 : $urandom_range(40, 1)));
            send_tile(int'(cfg_len_i), 2, $urandom_range(100, 30));
            wait_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
